// File: rtl/alu_arbiter.sv
// Two-requester front end for a single 64-bit ALU: arbitrates, registers operands,
// holds the ALU for ALU_LAT cycles and returns a registered result to the owner.
module alu_arbiter #(
  parameter int ALU_LAT    = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_greater,
  output logic        busy,
  output logic [31:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant, gnt_vld;
  logic        owner_p0;
  logic [3:0]  cnt_p0;
  logic [3:0]  op_p0;
  logic [63:0] a_p0, b_p0;
  logic        req_fire, exec_done, rsp_fire;
  logic [63:0] alu_res;
  logic        alu_zero, alu_gt;

  // Tie-break: fixed mode favours requester 0, round-robin favours whoever did not go last.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    else                          grant = ~req0_valid;
  end

  assign req_fire  = (state == IDLE) && gnt_vld;
  assign exec_done = (state == EXEC) && (cnt_p0 == 4'(ALU_LAT - 1));
  assign rsp_fire  = (state == RESP) && (owner_p0 ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire)  state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && gnt_vld && !grant;
    req1_ready = (state == IDLE) && gnt_vld &&  grant;
    rsp0_valid = (state == RESP) && !owner_p0;
    rsp1_valid = (state == RESP) &&  owner_p0;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner_p0   <= 1'b0;
      cnt_p0     <= '0;
      ops_done   <= '0;
    end else begin
      if (req_fire) begin
        owner_p0 <= grant;
        cnt_p0   <= '0;
      end else if (state == EXEC) begin
        cnt_p0 <= cnt_p0 + 4'd1;
      end
      if (rsp_fire) begin
        last_grant <= owner_p0;
        ops_done   <= ops_done + 32'd1;
      end
    end
  end

  // Operand stage: isolates the ALU inputs from the requesters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p0 <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
    end else if (req_fire) begin
      op_p0 <= grant ? req1_op : req0_op;
      a_p0  <= grant ? req1_a  : req0_a;
      b_p0  <= grant ? req1_b  : req0_b;
    end
  end

  // ALU core; a << b with the full 64-bit amount yields 0 for shifts >= 64.
  always_comb begin
    case (op_p0)
      4'b0000: alu_res = a_p0 & b_p0;
      4'b0001: alu_res = a_p0 | b_p0;
      4'b0010: alu_res = a_p0 + b_p0;
      4'b0110: alu_res = a_p0 - b_p0;
      4'b1100: alu_res = ~(a_p0 | b_p0);
      4'b0100: alu_res = (a_p0 < b_p0) ? 64'd0 : 64'd1;
      4'b0111: alu_res = a_p0 << b_p0;
      default: alu_res = 64'd0;
    endcase
    alu_zero = (alu_res == 64'd0);
    alu_gt   = (a_p0 > b_p0);
  end

  // Result stage: held until the owner drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_greater <= 1'b0;
    end else if (exec_done) begin
      rsp_result  <= alu_res;
      rsp_zero    <= alu_zero;
      rsp_greater <= alu_gt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin ALU_LAT=1 instance and a
// fixed-priority ALU_LAT=4 instance driven from one clock.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ALU_LAT=1, round-robin
  logic        a_rst;
  logic        a_q0v, a_q0r, a_q1v, a_q1r;
  logic [3:0]  a_q0op, a_q1op;
  logic [63:0] a_q0a, a_q0b, a_q1a, a_q1b;
  logic        a_s0v, a_s0r, a_s1v, a_s1r;
  logic [63:0] a_res;
  logic        a_zero, a_gt, a_busy;
  logic [31:0] a_ops;

  // Instance B: ALU_LAT=4, fixed priority
  logic        b_rst;
  logic        b_q0v, b_q0r, b_q1v, b_q1r;
  logic [3:0]  b_q0op, b_q1op;
  logic [63:0] b_q0a, b_q0b, b_q1a, b_q1b;
  logic        b_s0v, b_s0r, b_s1v, b_s1r;
  logic [63:0] b_res;
  logic        b_zero, b_gt, b_busy;
  logic [31:0] b_ops;

  alu_arbiter #(.ALU_LAT(1), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(a_rst),
    .req0_valid(a_q0v), .req0_ready(a_q0r), .req0_op(a_q0op), .req0_a(a_q0a), .req0_b(a_q0b),
    .req1_valid(a_q1v), .req1_ready(a_q1r), .req1_op(a_q1op), .req1_a(a_q1a), .req1_b(a_q1b),
    .rsp0_valid(a_s0v), .rsp0_ready(a_s0r), .rsp1_valid(a_s1v), .rsp1_ready(a_s1r),
    .rsp_result(a_res), .rsp_zero(a_zero), .rsp_greater(a_gt),
    .busy(a_busy), .ops_done(a_ops)
  );

  alu_arbiter #(.ALU_LAT(4), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(b_rst),
    .req0_valid(b_q0v), .req0_ready(b_q0r), .req0_op(b_q0op), .req0_a(b_q0a), .req0_b(b_q0b),
    .req1_valid(b_q1v), .req1_ready(b_q1r), .req1_op(b_q1op), .req1_a(b_q1a), .req1_b(b_q1b),
    .rsp0_valid(b_s0v), .rsp0_ready(b_s0r), .rsp1_valid(b_s1v), .rsp1_ready(b_s1r),
    .rsp_result(b_res), .rsp_zero(b_zero), .rsp_greater(b_gt),
    .busy(b_busy), .ops_done(b_ops)
  );

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_LES = 4'b0100,
                         OP_SHL = 4'b0111, OP_BAD = 4'b1111;

  int total = 0;
  int bad   = 0;
  int exp_ops;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on A requester 0 with rsp0_ready high and check the response.
  task automatic run_a0(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] res, input logic z,
                        input logic g);
    int waited;
    a_q0v = 1'b1; a_q0op = op; a_q0a = a; a_q0b = b; a_s0r = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(a_q0r), 64'd1);
    tick();
    a_q0v = 1'b0;
    waited = 0;
    while (!a_s0v && waited < 5) begin
      tick();
      waited++;
    end
    chk({tag, "_lat"}, 64'(waited), 64'd1);
    chk({tag, "_res"}, a_res, res);
    chk({tag, "_z"}, 64'(a_zero), 64'(z));
    chk({tag, "_g"}, 64'(a_gt), 64'(g));
    tick();
    exp_ops++;
    chk({tag, "_ops"}, 64'(a_ops), 64'(exp_ops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants0, viol, first_rsp;
    a_rst = 1'b1; b_rst = 1'b1;
    {a_q0v, a_q1v, a_s0r, a_s1r} = '0;
    {b_q0v, b_q1v, b_s0r, b_s1r} = '0;
    a_q0op = '0; a_q1op = '0; a_q0a = '0; a_q0b = '0; a_q1a = '0; a_q1b = '0;
    b_q0op = '0; b_q1op = '0; b_q0a = '0; b_q0b = '0; b_q1a = '0; b_q1b = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_s0v", 64'(a_s0v), 64'd0);
    chk("rst_ops", 64'(a_ops), 64'd0);
    chk("rst_res", a_res, 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();

    // Single ADD with latency T+2
    a_q0v = 1'b1; a_q0op = OP_ADD; a_q0a = 64'd5; a_q0b = 64'd7; a_s0r = 1'b1;
    #1;
    chk("t1_rdy0", 64'(a_q0r), 64'd1);
    chk("t1_rdy1", 64'(a_q1r), 64'd0);
    tick();
    a_q0v = 1'b0;
    chk("t1_busy", 64'(a_busy), 64'd1);
    chk("t1_s0v_early", 64'(a_s0v), 64'd0);
    tick();
    chk("t1_s0v", 64'(a_s0v), 64'd1);
    chk("t1_s1v", 64'(a_s1v), 64'd0);
    chk("t1_res", a_res, 64'd12);
    chk("t1_z", 64'(a_zero), 64'd0);
    chk("t1_g", 64'(a_gt), 64'd0);
    tick();
    chk("t1_ops", 64'(a_ops), 64'd1);
    chk("t1_idle", 64'(a_busy), 64'd0);

    // Round-robin from reset: req0 first, then req1
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    a_q0v = 1'b1; a_q0op = OP_SUB; a_q0a = 64'd9;    a_q0b = 64'd9;
    a_q1v = 1'b1; a_q1op = OP_OR;  a_q1a = 64'hF0;   a_q1b = 64'h0F;
    a_s0r = 1'b1; a_s1r = 1'b1;
    #1;
    chk("t2_rdy0", 64'(a_q0r), 64'd1);
    chk("t2_rdy1", 64'(a_q1r), 64'd0);
    tick();
    a_q0v = 1'b0;
    tick();
    chk("t2_s0v", 64'(a_s0v), 64'd1);
    chk("t2_s1v", 64'(a_s1v), 64'd0);
    chk("t2_res0", a_res, 64'd0);
    chk("t2_z0", 64'(a_zero), 64'd1);
    tick();
    chk("t2_rdy1b", 64'(a_q1r), 64'd1);
    chk("t2_ops1", 64'(a_ops), 64'd1);
    tick();
    a_q1v = 1'b0;
    tick();
    chk("t2_s1v_b", 64'(a_s1v), 64'd1);
    chk("t2_res1", a_res, 64'hFF);
    chk("t2_z1", 64'(a_zero), 64'd0);
    tick();
    chk("t2_ops2", 64'(a_ops), 64'd2);
    chk("t2_idle", 64'(a_busy), 64'd0);
    exp_ops = 2;

    // Edge and ordinary ops
    run_a0("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1);
    run_a0("shl64",    OP_SHL, 64'd1, 64'd64, 64'd0, 1'b1, 1'b0);
    run_a0("shl4",     OP_SHL, 64'd1, 64'd4, 64'd16, 1'b0, 1'b0);
    run_a0("badop",    OP_BAD, 64'd5, 64'd3, 64'd0, 1'b1, 1'b1);
    run_a0("les_lt",   OP_LES, 64'd3, 64'd4, 64'd0, 1'b1, 1'b0);
    run_a0("les_ge",   OP_LES, 64'd4, 64'd3, 64'd1, 1'b0, 1'b1);
    run_a0("nor",      OP_NOR, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_a0("sub_neg",  OP_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_a0("and",      OP_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b1);

    // Backpressure on requester 0 while requester 1 waits
    a_q0v = 1'b1; a_q0op = OP_ADD; a_q0a = 64'd10; a_q0b = 64'd20; a_s0r = 1'b0;
    #1;
    chk("bp_rdy0", 64'(a_q0r), 64'd1);
    tick();
    a_q0v = 1'b0;
    a_q1v = 1'b1; a_q1op = OP_OR; a_q1a = 64'd1; a_q1b = 64'd2;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_s0v", 64'(a_s0v), 64'd1);
      chk("bp_res", a_res, 64'd30);
      chk("bp_rdy1", 64'(a_q1r), 64'd0);
      tick();
    end
    a_s0r = 1'b1;
    tick();
    exp_ops++;
    chk("bp_idle", 64'(a_busy), 64'd0);
    chk("bp_s0v_off", 64'(a_s0v), 64'd0);
    chk("bp_ops", 64'(a_ops), 64'(exp_ops));
    chk("bp_rdy1_on", 64'(a_q1r), 64'd1);
    tick();
    a_q1v = 1'b0;
    tick();
    chk("bp_s1v", 64'(a_s1v), 64'd1);
    chk("bp_res1", a_res, 64'd3);
    tick();

    // Fixed priority on B: requester 1 never granted
    b_q0v = 1'b1; b_q0op = OP_ADD; b_q0a = 64'd1; b_q0b = 64'd2;
    b_q1v = 1'b1; b_q1op = OP_SUB; b_q1a = 64'd9; b_q1b = 64'd1;
    b_s0r = 1'b1; b_s1r = 1'b1;
    grants0 = 0; viol = 0; first_rsp = -1;
    #1;
    for (int c = 0; c < 18; c++) begin
      if (b_q0r) grants0++;
      if (b_q1r || b_s1v) viol++;
      if (b_s0v && first_rsp < 0) first_rsp = c;
      tick();
    end
    b_q0v = 1'b0; b_q1v = 1'b0;
    chk("fp_grants0", 64'(grants0), 64'd3);
    chk("fp_viol", 64'(viol), 64'd0);
    chk("fp_lat4", 64'(first_rsp), 64'd5);
    chk("fp_res", b_res, 64'd3);
    chk("fp_ops", 64'(b_ops), 64'd3);

    // Async reset mid-EXEC on B
    b_q0v = 1'b1; b_q0op = OP_ADD; b_q0a = 64'd7; b_q0b = 64'd8;
    #1;
    chk("ar_rdy0", 64'(b_q0r), 64'd1);
    tick();
    b_q0v = 1'b0;
    tick();
    chk("ar_busy_pre", 64'(b_busy), 64'd1);
    #2;
    b_rst = 1'b1;
    #1;
    chk("ar_busy", 64'(b_busy), 64'd0);
    chk("ar_s0v", 64'(b_s0v), 64'd0);
    chk("ar_ops", 64'(b_ops), 64'd0);
    chk("ar_res", b_res, 64'd0);
    tick();
    b_rst = 1'b0;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      if (b_s0v || b_s1v || b_busy) viol++;
      tick();
    end
    chk("ar_no_rsp", 64'(viol), 64'd0);
    chk("ar_ops_after", 64'(b_ops), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
